// File: rtl/uart_pkg.sv
// UART shared definitions: default divider widths,
// minimum divisor and the baud divisor helper.
package uart_pkg;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_OSR    = 16;
    localparam int MIN_DIV    = 2;

    typedef struct packed {
        logic [DEF_DIV_W-1:0]  div_int;
        logic [DEF_FRAC_W-1:0] div_frac;
    } baud_div_t;

    // Rounded clk/(baud*osr) in 1/2^FRAC_W steps, split into int/frac.
    function automatic baud_div_t baud_div(
        input longint clk_hz,
        input longint baud,
        input longint osr
    );
        longint    den;
        longint    q;
        baud_div_t r;
        den = baud * osr;
        q = (clk_hz * (longint'(1) << DEF_FRAC_W) + den / 2) / den;
        r.div_int  = DEF_DIV_W'(q >> DEF_FRAC_W);
        r.div_frac = DEF_FRAC_W'(q);
        return r;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional oversample divider: os counter, phase accumulator,
// active/shadow divisor pair and the registered os_tick.
module baud_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int DEF_INT  = 195,
    parameter int DEF_FRAC = 5
) (
    input  logic              clk30M,
    input  logic              nrst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              restart,
    output logic              os_fire,
    output logic              os_tick
);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  shd_int;
    logic [DIV_W-1:0]  int_eff;
    logic [DIV_W-1:0]  nxt_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] shd_frac;
    logic [FRAC_W-1:0] nxt_frac;
    logic [FRAC_W:0]   sum;
    logic [DIV_W:0]    last;

    // Period length of the running period and the wrap condition.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, act_frac};
        if (act_int < DIV_W'(MIN_DIV)) begin
            int_eff = DIV_W'(MIN_DIV);
        end else begin
            int_eff = act_int;
        end
        last = {1'b0, int_eff}
             + {{DIV_W{1'b0}}, sum[FRAC_W]}
             - {{DIV_W{1'b0}}, 1'b1};
        os_fire = en & ~restart & ({1'b0, cnt} >= last);
        nxt_int  = div_load ? div_int : shd_int;
        nxt_frac = div_load ? div_frac : shd_frac;
    end

    // Counter, accumulator and divisor registers; reload only at boundaries.
    always_ff @(posedge clk30M) begin
        if (!nrst) begin
            cnt      <= '0;
            acc      <= '0;
            act_int  <= DIV_W'(DEF_INT);
            act_frac <= FRAC_W'(DEF_FRAC);
            shd_int  <= DIV_W'(DEF_INT);
            shd_frac <= FRAC_W'(DEF_FRAC);
            os_tick  <= 1'b0;
        end else begin
            os_tick <= os_fire;
            if (div_load) begin
                shd_int  <= div_int;
                shd_frac <= div_frac;
            end
            if (restart) begin
                cnt      <= '0;
                acc      <= '0;
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
            end else if (!en) begin
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
            end else if (os_fire) begin
                cnt      <= '0;
                acc      <= sum[FRAC_W-1:0];
                act_int  <= shd_int;
                act_frac <= shd_frac;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: fractional oversample divider plus the
// bit counter with normal and mid-bit restart alignment.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int OSR      = DEF_OSR,
    parameter int DEF_INT  = 195,
    parameter int DEF_FRAC = 5
) (
    input  logic              clk30M,
    input  logic              nrst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              restart,
    input  logic              restart_mid,
    output logic              os_tick,
    output logic              bit_tick
);

    localparam int BW = $clog2(OSR + 1);
    localparam logic [BW-1:0] LAST = BW'(OSR - 1);
    localparam logic [BW-1:0] MID  =
        (OSR >= 2) ? BW'(OSR - OSR / 2) : BW'(0);

    logic          os_fire;
    logic [BW-1:0] bit_cnt;

    baud_frac_div #(
        .DIV_W    (DIV_W),
        .FRAC_W   (FRAC_W),
        .DEF_INT  (DEF_INT),
        .DEF_FRAC (DEF_FRAC)
    ) u_div (
        .clk30M   (clk30M),
        .nrst     (nrst),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .restart  (restart),
        .os_fire  (os_fire),
        .os_tick  (os_tick)
    );

    // Count oversample ticks; the last one of a bit also fires bit_tick.
    always_ff @(posedge clk30M) begin
        if (!nrst) begin
            bit_cnt  <= '0;
            bit_tick <= 1'b0;
        end else begin
            bit_tick <= os_fire & (bit_cnt == LAST);
            if (restart) begin
                bit_cnt <= restart_mid ? MID : '0;
            end else if (os_fire) begin
                if (bit_cnt == LAST) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: two instances (OSR=16 and OSR=1),
// per-cycle reference model plus directed timing figures.
module tb_baud_tick_gen;
    import uart_pkg::*;

    logic        clk30M;
    logic        nrst;
    logic        en;
    logic        div_load;
    logic        restart;
    logic        restart_mid;
    logic [15:0] di_a;
    logic [15:0] di_b;
    logic [3:0]  df_a;
    logic [3:0]  df_b;
    logic        os_a;
    logic        bit_a;
    logic        os_b;
    logic        bit_b;

    int n_cmp = 0;
    int n_err = 0;

    int m_osr[2]   = '{16, 1};
    int m_dint[2]  = '{195, 3125};
    int m_dfrac[2] = '{5, 0};
    int m_ai[2];
    int m_af[2];
    int m_si[2];
    int m_sf[2];
    int m_acc[2];
    int m_el[2];
    int m_nb[2];
    logic m_os[2];
    logic m_bit[2];
    bit m_started = 1'b0;

    int na;
    int nb;
    int nc;
    int c195;
    int c196;
    int bsum;

    initial clk30M = 1'b0;
    always #5 clk30M = ~clk30M;

    baud_tick_gen #(
        .DIV_W(16), .FRAC_W(4), .OSR(16),
        .DEF_INT(195), .DEF_FRAC(5)
    ) u_a (
        .clk30M(clk30M), .nrst(nrst), .en(en),
        .div_int(di_a), .div_frac(df_a), .div_load(div_load),
        .restart(restart), .restart_mid(restart_mid),
        .os_tick(os_a), .bit_tick(bit_a)
    );

    baud_tick_gen #(
        .DIV_W(16), .FRAC_W(4), .OSR(1),
        .DEF_INT(3125), .DEF_FRAC(0)
    ) u_b (
        .clk30M(clk30M), .nrst(nrst), .en(en),
        .div_int(di_b), .div_frac(df_b), .div_load(div_load),
        .restart(restart), .restart_mid(restart_mid),
        .os_tick(os_b), .bit_tick(bit_b)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    // Reference: each period lasts max(int,2) cycles plus one whenever the
    // running fraction sum overflows 16; a bit ends every OSR periods.
    task automatic model_step();
        int vi;
        int vf;
        int ni;
        int nf;
        int pe;
        for (int i = 0; i < 2; i++) begin
            vi = (i == 0) ? int'(di_a) : int'(di_b);
            vf = (i == 0) ? int'(df_a) : int'(df_b);
            ni = div_load ? vi : m_si[i];
            nf = div_load ? vf : m_sf[i];
            m_os[i]  = 1'b0;
            m_bit[i] = 1'b0;
            if (!nrst) begin
                m_ai[i]  = m_dint[i];
                m_af[i]  = m_dfrac[i];
                ni       = m_dint[i];
                nf       = m_dfrac[i];
                m_acc[i] = 0;
                m_el[i]  = 0;
                m_nb[i]  = m_osr[i];
            end else if (restart) begin
                m_ai[i]  = ni;
                m_af[i]  = nf;
                m_acc[i] = 0;
                m_el[i]  = 0;
                m_nb[i]  = (restart_mid && m_osr[i] >= 2) ?
                           m_osr[i] / 2 : m_osr[i];
            end else if (!en) begin
                m_ai[i] = ni;
                m_af[i] = nf;
            end else begin
                pe = (m_ai[i] < 2 ? 2 : m_ai[i]) +
                     ((m_acc[i] + m_af[i]) >= 16 ? 1 : 0);
                m_el[i]++;
                if (m_el[i] >= pe) begin
                    m_os[i]  = 1'b1;
                    m_el[i]  = 0;
                    m_acc[i] = (m_acc[i] + m_af[i]) % 16;
                    m_ai[i]  = m_si[i];
                    m_af[i]  = m_sf[i];
                    m_nb[i]--;
                    if (m_nb[i] == 0) begin
                        m_bit[i] = 1'b1;
                        m_nb[i]  = m_osr[i];
                    end
                end
            end
            m_si[i] = ni;
            m_sf[i] = nf;
        end
        m_started = 1'b1;
    endtask

    always @(posedge clk30M) model_step();

    always @(negedge clk30M) begin
        if (m_started) begin
            chk("os_a", os_a, m_os[0]);
            chk("bit_a", bit_a, m_bit[0]);
            chk("os_b", os_b, m_os[1]);
            chk("bit_b", bit_b, m_bit[1]);
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0:       return os_a;
            1:       return bit_a;
            2:       return os_b;
            default: return bit_b;
        endcase
    endfunction

    // Negedges until the selected output is seen high; -1 on timeout.
    task automatic wait_tick(input int s, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk30M);
            n++;
        end while (!sig(s) && n < lim);
        if (!sig(s)) n = -1;
    endtask

    task automatic pulse(input logic ld, input logic rs, input logic mid);
        div_load    = ld;
        restart     = rs;
        restart_mid = mid;
        @(negedge clk30M);
        div_load    = 1'b0;
        restart     = 1'b0;
        restart_mid = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1;
        div_load = 1'b0; restart = 1'b0; restart_mid = 1'b0;
        di_a = 16'd195; df_a = 4'd5;
        di_b = 16'd3125; df_b = 4'd0;

        chk_int("baud_div_16", int'(baud_div(30000000, 9600, 16)),
                (195 << 4) | 5);
        chk_int("baud_div_1", int'(baud_div(30000000, 9600, 1)),
                3125 << 4);

        repeat (5) begin
            @(negedge clk30M);
            chk("rst_os", os_a, 1'b0);
            chk("rst_bit", bit_a, 1'b0);
        end
        nrst = 1'b1;
        wait_tick(0, 400, na);
        chk_int("first_os_after_reset", na, 195);

        pulse(1'b1, 1'b1, 1'b0);
        fork
            begin
                for (int j = 0; j < 20; j++) begin
                    wait_tick(3, 3200, nb);
                    chk_int("int_bit_gap", nb, 3125);
                end
            end
            begin
                wait_tick(0, 300, na);
                chk_int("frac_first_os", na, 195);
                c195 = 0;
                c196 = 0;
                for (int j = 0; j < 16; j++) begin
                    wait_tick(0, 300, na);
                    if (na == 195) c195++;
                    else if (na == 196) c196++;
                end
                chk_int("frac_n196", c196, 5);
                chk_int("frac_n195", c195, 11);
            end
            begin
                wait_tick(1, 3300, nc);
                chk_int("frac_first_bit", nc, 3125);
                bsum = 0;
                for (int j = 0; j < 16; j++) begin
                    wait_tick(1, 3300, nc);
                    bsum += nc;
                end
                chk_int("frac_bit_sum16", bsum, 50000);
            end
        join

        di_a = 16'd4; df_a = 4'd0;
        pulse(1'b1, 1'b1, 1'b1);
        fork
            begin
                wait_tick(0, 20, na);
                chk_int("mid_first_os", na, 4);
            end
            begin
                wait_tick(1, 100, nb);
                chk_int("mid_first_bit", nb, 32);
                for (int j = 0; j < 3; j++) begin
                    wait_tick(1, 100, nb);
                    chk_int("mid_bit_gap", nb, 64);
                end
            end
        join

        di_a = 16'd10;
        pulse(1'b1, 1'b1, 1'b0);
        wait_tick(0, 50, na);
        chk_int("reload_base", na, 10);
        repeat (2) @(negedge clk30M);
        di_a = 16'd20;
        pulse(1'b1, 1'b0, 1'b0);
        wait_tick(0, 50, na);
        chk_int("reload_cur_period", na + 3, 10);
        wait_tick(0, 50, na);
        chk_int("reload_next_period", na, 20);
        di_a = 16'd10;
        pulse(1'b1, 1'b0, 1'b0);
        di_a = 16'd20;
        pulse(1'b1, 1'b1, 1'b0);
        wait_tick(0, 50, na);
        chk_int("load_with_restart", na, 20);

        repeat (5) @(negedge clk30M);
        en = 1'b0;
        repeat (7) @(negedge clk30M);
        en = 1'b1;
        wait_tick(0, 50, na);
        chk_int("hold_delay", na + 12, 27);

        repeat (5) @(negedge clk30M);
        nrst = 1'b0;
        repeat (2) @(negedge clk30M);
        nrst = 1'b1;
        wait_tick(0, 400, na);
        chk_int("os_after_mid_reset", na, 195);

        for (int j = 0; j < 4000; j++) begin
            en          = ($urandom_range(0, 9) != 0);
            div_load    = ($urandom_range(0, 19) == 0);
            di_a        = 16'($urandom_range(0, 12));
            df_a        = 4'($urandom_range(0, 15));
            di_b        = 16'($urandom_range(0, 12));
            df_b        = 4'($urandom_range(0, 15));
            restart     = ($urandom_range(0, 49) == 0);
            restart_mid = ($urandom_range(0, 1) == 1);
            nrst        = ($urandom_range(0, 499) != 0);
            @(negedge clk30M);
        end
        nrst = 1'b1; en = 1'b1;
        div_load = 1'b0; restart = 1'b0; restart_mid = 1'b0;
        repeat (4) @(negedge clk30M);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
